hsv_color_judge: RTL and testbench

Consumes the per-pixel HSV stream from the RGB-to-HSV converter and sorts every valid pixel into one of eight colour classes. It counts the class hits across one frame, or one ROI window. At frame end it scans the counters sequentially and reports the dominant colour class and its pixel count to the menu/display logic.

---
 rtl/hsv_pkg.sv | 53 +++++
 rtl/hsv_classify.sv | 29 ++
 rtl/hsv_color_judge.sv | 105 ++++++++++
 tb/tb_hsv_color_judge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// hsv_pkg: shared class codes, hue bin edges, FSM states and pixel classifier for the HSV colour judge
package hsv_pkg;

    localparam int DEF_CNT_W = 20;
    localparam int DEF_MIN_PIX = 1024;
    localparam logic [7:0] DEF_V_MIN = 8'd40;
    localparam logic [7:0] DEF_S_MIN = 8'd60;

    localparam logic [8:0] HUE_YELLOW = 9'd30;
    localparam logic [8:0] HUE_GREEN = 9'd90;
    localparam logic [8:0] HUE_CYAN = 9'd150;
    localparam logic [8:0] HUE_BLUE = 9'd210;
    localparam logic [8:0] HUE_MAGENTA = 9'd270;
    localparam logic [8:0] HUE_RED = 9'd330;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RED,
        CLS_YELLOW,
        CLS_GREEN,
        CLS_CYAN,
        CLS_BLUE,
        CLS_MAGENTA,
        CLS_GRAY
    } cls_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_CMP,
        S_DONE
    } state_t;

    // Dark pixels are BLACK (shares code 0 with NONE), washed-out pixels are GRAY,
    // everything else falls into a 60-degree hue bin; out-of-range hue counts as RED.
    function automatic cls_t hue_class(
        input logic [8:0] h,
        input logic [7:0] s,
        input logic [7:0] v,
        input logic [7:0] v_min,
        input logic [7:0] s_min
    );
        return v < v_min ? CLS_NONE :
               s < s_min ? CLS_GRAY :
               (h < HUE_YELLOW || h >= HUE_RED) ? CLS_RED :
               h < HUE_GREEN ? CLS_YELLOW :
               h < HUE_CYAN ? CLS_GREEN :
               h < HUE_BLUE ? CLS_CYAN :
               h < HUE_MAGENTA ? CLS_BLUE : CLS_MAGENTA;
    endfunction

endpackage

// File: rtl/hsv_classify.sv
// hsv_classify: registered per-pixel HSV to colour-class mapper
module hsv_classify
    import hsv_pkg::*;
#(
    parameter logic [7:0] V_MIN = DEF_V_MIN,
    parameter logic [7:0] S_MIN = DEF_S_MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] h,
    input  logic [7:0] s,
    input  logic [7:0] v,
    output cls_t       cls,
    output logic       cls_valid
);

    // One-cycle classification stage with its own valid bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls <= CLS_NONE;
            cls_valid <= 1'b0;
        end else begin
            cls <= hue_class(h, s, v, V_MIN, S_MIN);
            cls_valid <= in_valid;
        end
    end

endmodule

// File: rtl/hsv_color_judge.sv
// hsv_color_judge: per-frame colour-class histogram with sequential dominant-class scan
module hsv_color_judge
    import hsv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter logic [7:0] V_MIN = DEF_V_MIN,
    parameter logic [7:0] S_MIN = DEF_S_MIN,
    parameter logic [CNT_W-1:0] MIN_PIX = CNT_W'(DEF_MIN_PIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pix_valid,
    input  logic [8:0]       hsv_h,
    input  logic [7:0]       hsv_s,
    input  logic [7:0]       hsv_v,
    output logic [2:0]       color_id,
    output logic [CNT_W-1:0] color_cnt,
    output logic             color_valid,
    output logic             busy
);

    state_t state;
    cls_t pix_cls;
    logic pix_hit;
    logic [2:0] idx;
    logic [CNT_W-1:0] counts [8];
    logic [CNT_W-1:0] best_cnt;
    cls_t best_id;
    logic take;
    logic [CNT_W-1:0] scan_cnt;
    cls_t scan_id;
    logic clear;

    hsv_classify #(.V_MIN(V_MIN), .S_MIN(S_MIN)) u_classify (
        .clk(clk),
        .rst(rst),
        .in_valid(pix_valid && state == S_ACC),
        .h(hsv_h),
        .s(hsv_s),
        .v(hsv_v),
        .cls(pix_cls),
        .cls_valid(pix_hit)
    );

    assign busy = state == S_CMP;
    assign clear = frame_start && (state == S_IDLE || state == S_ACC);

    // One scan step: class 0 never wins, ties keep the earlier (lower) class
    always_comb begin
        take = idx != 3'd0 && counts[idx] > best_cnt;
        scan_cnt = take ? counts[idx] : best_cnt;
        scan_id = take ? cls_t'(idx) : best_id;
    end

    // Class histogram: window start clears, drained pixels still land during FLUSH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) counts[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < 8; k++) counts[k] <= '0;
        end else if (pix_hit && (state == S_ACC || state == S_FLUSH) && counts[pix_cls] != '1) begin
            counts[pix_cls] <= counts[pix_cls] + 1'b1;
        end
    end

    // Frame FSM; the result registers load on the last scan step so color_valid coincides with DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx <= 3'd0;
            best_cnt <= '0;
            best_id <= CLS_NONE;
            color_id <= 3'd0;
            color_cnt <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= 1'b0;
            case (state)
                S_IDLE: state <= frame_start ? S_ACC : S_IDLE;
                S_ACC: state <= (frame_end && !frame_start) ? S_FLUSH : S_ACC;
                S_FLUSH: begin
                    state <= S_CMP;
                    idx <= 3'd0;
                    best_cnt <= '0;
                    best_id <= CLS_NONE;
                end
                S_CMP: begin
                    best_cnt <= scan_cnt;
                    best_id <= scan_id;
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state <= S_DONE;
                        color_id <= scan_cnt < MIN_PIX ? CLS_NONE : scan_id;
                        color_cnt <= scan_cnt;
                        color_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_color_judge.sv
// tb_hsv_color_judge: directed and randomized frames checked against a histogram reference model
module tb_hsv_color_judge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic frame_end = 1'b0;
    logic pix_valid = 1'b0;
    logic [8:0] hsv_h = '0;
    logic [7:0] hsv_s = '0;
    logic [7:0] hsv_v = '0;
    logic [2:0] color_id;
    logic [19:0] color_cnt;
    logic color_valid;
    logic busy;

    int checks = 0;
    int errors = 0;
    int model [8];
    int last_cnt = 0;

    hsv_color_judge dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .pix_valid(pix_valid),
        .hsv_h(hsv_h),
        .hsv_s(hsv_s),
        .hsv_v(hsv_v),
        .color_id(color_id),
        .color_cnt(color_cnt),
        .color_valid(color_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_class(input int h, input int s, input int v);
        if (v < 40) return 0;
        if (s < 60) return 7;
        if (h > 359) return 1;
        return ((h + 30) / 60) % 6 + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int s, input int v);
        pix_valid = 1'b1;
        hsv_h = 9'(h);
        hsv_s = 8'(s);
        hsv_v = 8'(v);
        model[ref_class(h, s, v)]++;
        step();
        pix_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        for (int k = 0; k < 8; k++) model[k] = 0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        for (int k = 0; k < 8; k++) check($sformatf("%s_cnt%0d", tag, k), 32'(dut.counts[k]), 32'(model[k]));
    endtask

    // frame_end (optionally with a last pixel), then latency, busy span and result checks
    task automatic finish_frame(input string tag, input bit with_pix, input int h, input int s, input int v);
        int n, busy_cycles, best, best_id;
        frame_end = 1'b1;
        if (with_pix) begin
            pix_valid = 1'b1;
            hsv_h = 9'(h);
            hsv_s = 8'(s);
            hsv_v = 8'(v);
            model[ref_class(h, s, v)]++;
        end
        step();
        frame_end = 1'b0;
        pix_valid = 1'b0;
        n = 1;
        busy_cycles = busy === 1'b1 ? 1 : 0;
        while (color_valid !== 1'b1 && n < 30) begin
            step();
            n++;
            if (busy === 1'b1) busy_cycles++;
        end
        best = 0;
        best_id = 0;
        for (int k = 1; k < 8; k++) if (model[k] > best) begin
            best = model[k];
            best_id = k;
        end
        if (best < 1024) best_id = 0;
        last_cnt = best;
        check({tag, "_latency"}, n, 10);
        check({tag, "_busy_cycles"}, busy_cycles, 8);
        check({tag, "_id"}, 32'(color_id), 32'(best_id));
        check({tag, "_cnt"}, 32'(color_cnt), 32'(best));
        step();
        check({tag, "_valid_pulse"}, 32'(color_valid), 0);
        check({tag, "_hold_cnt"}, 32'(color_cnt), 32'(best));
    endtask

    initial begin
        int pulses, fav;
        for (int k = 0; k < 8; k++) model[k] = 0;
        step();
        step();
        check("rst_id", 32'(color_id), 0);
        check("rst_cnt", 32'(color_cnt), 0);
        check("rst_valid", 32'(color_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        step();

        start_frame();
        for (int i = 0; i < 1999; i++) pix(120, 200, 200);
        finish_frame("green", 1'b1, 120, 200, 200);

        start_frame();
        for (int i = 0; i < 1500; i++) begin
            pix(350, 200, 200);
            pix(240, 200, 200);
        end
        finish_frame("tie", 1'b0, 0, 0, 0);

        start_frame();
        for (int i = 0; i < 500; i++) pix(60, 200, 200);
        finish_frame("below_min", 1'b0, 0, 0, 0);

        start_frame();
        for (int i = 0; i < 1200; i++) pix(100, 30, 200);
        for (int i = 0; i < 3000; i++) pix(100, 200, 10);
        finish_frame("gray", 1'b0, 0, 0, 0);

        start_frame();
        pix(29, 200, 200);
        pix(30, 200, 200);
        pix(329, 200, 200);
        finish_frame("edges", 1'b1, 330, 200, 200);
        check_counters("edges");

        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (color_valid === 1'b1) pulses++;
        end
        check("idle_end_pulses", pulses, 0);
        check("idle_end_hold", 32'(color_cnt), 32'(last_cnt));

        start_frame();
        for (int i = 0; i < 700; i++) pix(0, 200, 200);
        start_frame();
        for (int i = 0; i < 1100; i++) pix(180, 200, 200);
        finish_frame("restart", 1'b0, 0, 0, 0);
        check_counters("restart");

        start_frame();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            else pix($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        finish_frame("rand_uniform", 1'b1, $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));

        for (int f = 0; f < 3; f++) begin
            fav = $urandom_range(0, 5);
            start_frame();
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 9) < 7)
                    pix((fav * 60 + 330 + $urandom_range(0, 59)) % 360, $urandom_range(60, 255), $urandom_range(40, 255));
                else
                    pix($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
            end
            finish_frame($sformatf("rand_bias%0d", f), 1'b0, 0, 0, 0);
            check_counters($sformatf("rand_bias%0d", f));
        end

        start_frame();
        for (int i = 0; i < 1200; i++) pix(120, 200, 200);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #2;
        check("abort_id", 32'(color_id), 0);
        check("abort_cnt", 32'(color_cnt), 0);
        check("abort_busy", 32'(busy), 0);
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (color_valid === 1'b1) pulses++;
        end
        check("abort_pulses", pulses, 0);
        for (int k = 0; k < 8; k++) model[k] = 0;
        check_counters("abort");

        start_frame();
        for (int i = 0; i < 1300; i++) pix(280, 200, 200);
        finish_frame("recover", 1'b0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
